// File: rtl/sprite_arb_pkg.sv
// Shared constants and tag type for the sprite ROM arbiter and pixel generators.
package sprite_arb_pkg;

  localparam int SPRITE_ROM_AW  = 10;
  localparam int SPRITE_ROM_DW  = 18;
  localparam int SPRITE_ROM_LAT = 1;

  typedef struct packed {
    logic       valid;
    logic [2:0] index;
  } sprite_tag_t;

  function automatic int wrap_idx(input int base, input int off, input int n);
    wrap_idx = (base + off) % n;
  endfunction

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Requester/ROM bus of the sprite ROM arbiter. master = requesters plus ROM, slave = arbiter.
interface sprite_rom_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 10,
  parameter int DW   = 18
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_ready;
  logic               hold;
  logic [AW-1:0]      rom_addr;
  logic               rom_rd;
  logic [DW-1:0]      rom_data;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               busy;

  modport master (
    output req_valid, req_addr, hold, rom_data,
    input  req_ready, rom_addr, rom_rd, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_addr, hold, rom_data,
    output req_ready, rom_addr, rom_rd, rsp_valid, rsp_data, busy
  );

endinterface

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after index 'last', wrapping.
module rr_pick
  import sprite_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      last,
  output logic [NREQ-1:0] grant,
  output logic [2:0]      idx,
  output logic            found
);

  int cand_s;

  // Scan NREQ positions starting just after the previous winner.
  always_comb begin
    grant  = '0;
    idx    = 3'd0;
    found  = 1'b0;
    cand_s = 0;
    for (int off = 1; off <= NREQ; off++) begin
      cand_s = wrap_idx(int'(last), off, NREQ);
      if (!found && req[cand_s]) begin
        found         = 1'b1;
        grant[cand_s] = 1'b1;
        idx           = 3'(cand_s);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM port between NREQ requesters.
// Define SPRITE_ARB_PRIORITY0_EN to give requester 0 fixed highest priority.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int AW      = SPRITE_ROM_AW,
  parameter int DW      = SPRITE_ROM_DW,
  parameter int ROM_LAT = SPRITE_ROM_LAT
) (
  input logic                 CLK,
  input logic                 CLR,
  sprite_rom_arbiter_if.slave bus
);

  localparam logic [NREQ-1:0] REQ0_ONEHOT = {{(NREQ-1){1'b0}}, 1'b1};

  logic [2:0]           last_grant_r;
  logic [NREQ-1:0]      pick_req_s;
  logic [NREQ-1:0]      pick_grant_s;
  logic [2:0]           pick_idx_s;
  logic                 pick_found_s;
  logic [NREQ-1:0]      grant_s;
  logic [2:0]           grant_idx_s;
  logic                 hs_s;
  logic                 last_upd_s;
  logic [AW-1:0]        grant_addr_s;
  sprite_tag_t          new_tag_s;
  sprite_tag_t          rsp_tag_s;
  sprite_tag_t [ROM_LAT:0] tag_r;
  logic                 busy_next_s;
  logic [AW-1:0]        rom_addr_r;
  logic                 rom_rd_r;
  logic [NREQ-1:0]      rsp_valid_r;
  logic [DW-1:0]        rsp_data_r;
  logic                 busy_r;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (pick_req_s),
    .last  (last_grant_r),
    .grant (pick_grant_s),
    .idx   (pick_idx_s),
    .found (pick_found_s)
  );

`ifdef SPRITE_ARB_PRIORITY0_EN
  // Requester 0 is outside the rotation and never moves last_grant.
  assign pick_req_s = bus.req_valid & ~REQ0_ONEHOT;

  // Grant select: hold blocks everything, then requester 0, then the rotation.
  always_comb begin
    grant_s     = '0;
    grant_idx_s = 3'd0;
    hs_s        = 1'b0;
    last_upd_s  = 1'b0;
    if (bus.hold) begin
      grant_s = '0;
    end else if (bus.req_valid[0]) begin
      grant_s = REQ0_ONEHOT;
      hs_s    = 1'b1;
    end else if (pick_found_s) begin
      grant_s     = pick_grant_s;
      grant_idx_s = pick_idx_s;
      hs_s        = 1'b1;
      last_upd_s  = 1'b1;
    end else begin
      grant_s = '0;
    end
  end
`else
  assign pick_req_s = bus.req_valid;

  // Grant select: plain round-robin, suppressed by hold.
  always_comb begin
    grant_s     = '0;
    grant_idx_s = 3'd0;
    hs_s        = 1'b0;
    last_upd_s  = 1'b0;
    if (!bus.hold && pick_found_s) begin
      grant_s     = pick_grant_s;
      grant_idx_s = pick_idx_s;
      hs_s        = 1'b1;
      last_upd_s  = 1'b1;
    end else begin
      grant_s = '0;
    end
  end
`endif

  assign grant_addr_s = bus.req_addr[int'(grant_idx_s)*AW +: AW];
  assign rsp_tag_s    = tag_r[ROM_LAT];

  // Next tag entry and busy; busy covers every tag still in the pipe after the shift.
  always_comb begin
    new_tag_s       = '0;
    new_tag_s.valid = hs_s;
    new_tag_s.index = grant_idx_s;
    busy_next_s     = hs_s;
    for (int i = 0; i < ROM_LAT; i++) begin
      busy_next_s = busy_next_s | tag_r[i].valid;
    end
  end

  // ROM address/strobe, tag pipeline and response registers.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      last_grant_r <= 3'(NREQ - 1);
      tag_r        <= '0;
      rom_addr_r   <= '0;
      rom_rd_r     <= 1'b0;
      rsp_valid_r  <= '0;
      rsp_data_r   <= '0;
      busy_r       <= 1'b0;
    end else begin
      if (last_upd_s) begin
        last_grant_r <= grant_idx_s;
      end else begin
        last_grant_r <= last_grant_r;
      end
      if (hs_s) begin
        rom_addr_r <= grant_addr_s;
      end else begin
        rom_addr_r <= rom_addr_r;
      end
      rom_rd_r <= hs_s;
      tag_r    <= {tag_r[ROM_LAT-1:0], new_tag_s};
      if (rsp_tag_s.valid) begin
        rsp_valid_r <= REQ0_ONEHOT << rsp_tag_s.index;
        rsp_data_r  <= bus.rom_data;
      end else begin
        rsp_valid_r <= '0;
        rsp_data_r  <= rsp_data_r;
      end
      busy_r <= busy_next_s;
    end
  end

  assign bus.req_ready = grant_s;
  assign bus.rom_addr  = rom_addr_r;
  assign bus.rom_rd    = rom_rd_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: queue-based reference model plus directed literal checks.
module tb_sprite_rom_arbiter;

  localparam int NREQ    = 4;
  localparam int AW      = 10;
  localparam int DW      = 18;
  localparam int ROM_LAT = 1;

  logic CLK;
  logic CLR;
  int   checks;
  int   errors;

  sprite_rom_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  sprite_rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .ROM_LAT(ROM_LAT)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ROM contents: {addr[7:0], addr} ^ 18'h2A5C3
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    rom_word = {a[7:0], a} ^ 18'h2A5C3;
  endfunction

  logic [DW-1:0] rom_q [ROM_LAT];
  always @(posedge CLK) begin
    rom_q[0] <= rom_word(bus.rom_addr);
    for (int i = 1; i < ROM_LAT; i++) rom_q[i] <= rom_q[i-1];
  end
  assign bus.rom_data = rom_q[ROM_LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int            idx;
    logic [AW-1:0] addr;
    int            due;
  } pend_t;

  pend_t         pend[$];
  int            m_last;
  int            cyc;
  int            g;
  logic [AW-1:0] e_rom_addr;
  logic          e_rom_rd;
  logic [3:0]    e_rsp_valid;
  logic [DW-1:0] e_rsp_data;
  logic          e_busy;
  logic [3:0]    e_ready;

  function automatic int model_grant(input logic [3:0] v, input logic h, input int last);
    if (h) return -1;
`ifdef SPRITE_ARB_PRIORITY0_EN
    if (v[0]) return 0;
`endif
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (last + k) % NREQ;
`ifdef SPRITE_ARB_PRIORITY0_EN
      if (i == 0) continue;
`endif
      if (v[i]) return i;
    end
    return -1;
  endfunction

  always @(negedge CLK) begin
    if (!CLR) begin
      pend.delete();
      m_last      = NREQ - 1;
      e_rom_addr  = '0;
      e_rom_rd    = 1'b0;
      e_rsp_valid = 4'b0000;
      e_rsp_data  = '0;
      chk("rst_rom_addr", bus.rom_addr, 32'd0);
      chk("rst_rom_rd", bus.rom_rd, 32'd0);
      chk("rst_rsp_valid", bus.rsp_valid, 32'd0);
      chk("rst_rsp_data", bus.rsp_data, 32'd0);
      chk("rst_busy", bus.busy, 32'd0);
    end else begin
      cyc++;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        e_rsp_valid = 4'b0001 << pend[0].idx;
        e_rsp_data  = rom_word(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        e_rsp_valid = 4'b0000;
      end
      e_busy = (pend.size() != 0);
      chk("m_rom_addr", bus.rom_addr, e_rom_addr);
      chk("m_rom_rd", bus.rom_rd, e_rom_rd);
      chk("m_rsp_valid", bus.rsp_valid, e_rsp_valid);
      chk("m_rsp_data", bus.rsp_data, e_rsp_data);
      chk("m_busy", bus.busy, e_busy);
      g = model_grant(bus.req_valid, bus.hold, m_last);
      e_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      chk("m_req_ready", bus.req_ready, e_ready);
      if (g >= 0) begin
        pend.push_back('{idx: g, addr: bus.req_addr[g*AW +: AW], due: cyc + ROM_LAT + 2});
        e_rom_addr = bus.req_addr[g*AW +: AW];
        e_rom_rd   = 1'b1;
`ifdef SPRITE_ARB_PRIORITY0_EN
        if (g != 0) m_last = g;
`else
        m_last = g;
`endif
      end else begin
        e_rom_rd = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [AW-1:0] addr_r [NREQ];
  logic [3:0]    rdy;
  logic [3:0]    one;

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    addr_r[i] = a;
    bus.req_addr[i*AW +: AW] = a;
  endtask

  task automatic advance(input logic [3:0] r);
    for (int i = 0; i < NREQ; i++) if (r[i]) set_addr(i, addr_r[i] + 10'd1);
  endtask

  task automatic step(output logic [3:0] r);
    @(negedge CLK);
    #1 r = bus.req_ready;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    CLR           = 1'b0;
    bus.req_valid = 4'b0000;
    bus.hold      = 1'b0;
    repeat (2) @(posedge CLK);
    #1 CLR = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    one    = 4'b0001;
    for (int i = 0; i < NREQ; i++) set_addr(i, 10'h000);
    do_reset();
    chk("t0_rom_addr", bus.rom_addr, 32'h000);
    chk("t0_busy", bus.busy, 32'd0);

    // single request from requester 2
    set_addr(2, 10'h155);
    bus.req_valid = 4'b0100;
    step(rdy);
    chk("t1_ready", rdy, 32'h4);
    bus.req_valid = 4'b0000;
    chk("t1_rom_addr", bus.rom_addr, 32'h155);
    chk("t1_rom_rd", bus.rom_rd, 32'd1);
    step(rdy);
    step(rdy);
    chk("t1_rsp_valid", bus.rsp_valid, 32'h4);
    chk("t1_rsp_data", bus.rsp_data, 32'h3F096);
    step(rdy);
    chk("t1_busy_idle", bus.busy, 32'd0);

`ifndef SPRITE_ARB_PRIORITY0_EN
    // all four continuously valid from reset
    do_reset();
    for (int i = 0; i < NREQ; i++) set_addr(i, 10'h100 + 10'(i * 16));
    bus.req_valid = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      step(rdy);
      chk("t2_grant", rdy, one << (n % 4));
      advance(rdy);
    end
    bus.req_valid = 4'b0000;
    repeat (4) step(rdy);
`endif

    // requester 1 alone, five back-to-back grants
    set_addr(1, 10'h010);
    bus.req_valid = 4'b0010;
    repeat (5) begin
      step(rdy);
      chk("t3_grant", rdy, 32'h2);
      advance(rdy);
    end
    bus.req_valid = 4'b0000;
    chk("t3_last_addr", bus.rom_addr, 32'h014);
    repeat (4) step(rdy);

`ifndef SPRITE_ARB_PRIORITY0_EN
    // hold window with reads in flight
    bus.req_valid = 4'b1111;
    step(rdy);
    chk("t4_grant_a", rdy, 32'h4);
    advance(rdy);
    step(rdy);
    chk("t4_grant_b", rdy, 32'h8);
    advance(rdy);
    chk("t4_busy_on", bus.busy, 32'd1);
    bus.hold = 1'b1;
    repeat (4) begin
      step(rdy);
      chk("t4_hold_ready", rdy, 32'h0);
    end
    chk("t4_busy_off", bus.busy, 32'd0);
    bus.hold = 1'b0;
    step(rdy);
    chk("t4_resume", rdy, 32'h1);
    advance(rdy);
    bus.req_valid = 4'b0000;
    repeat (4) step(rdy);
`else
    // requester 0 dominates, then 1 and 3 alternate
    do_reset();
    bus.req_valid = 4'b1011;
    repeat (3) begin
      step(rdy);
      chk("p_grant0", rdy, 32'h1);
      advance(rdy);
    end
    bus.req_valid = 4'b1010;
    for (int n = 0; n < 4; n++) begin
      step(rdy);
      chk("p_alt", rdy, (n % 2 == 0) ? 32'h2 : 32'h8);
      advance(rdy);
    end
    bus.req_valid = 4'b0000;
    repeat (4) step(rdy);
`endif

    // reset with two reads in flight
    bus.req_valid = 4'b1111;
    step(rdy);
    advance(rdy);
    step(rdy);
    advance(rdy);
    #1;
    CLR           = 1'b0;
    bus.req_valid = 4'b0000;
    #1;
    chk("t5_rom_addr", bus.rom_addr, 32'h0);
    chk("t5_rom_rd", bus.rom_rd, 32'd0);
    chk("t5_rsp_valid", bus.rsp_valid, 32'h0);
    chk("t5_rsp_data", bus.rsp_data, 32'h0);
    chk("t5_busy", bus.busy, 32'd0);
    chk("t5_ready", bus.req_ready, 32'h0);
    @(posedge CLK);
    #1 CLR = 1'b1;
    repeat (4) begin
      step(rdy);
      chk("t5_no_rsp", bus.rsp_valid, 32'h0);
    end
    bus.req_valid = 4'b1111;
    step(rdy);
    chk("t5_first_grant", rdy, 32'h1);
    advance(rdy);
    bus.req_valid = 4'b0000;
    repeat (4) step(rdy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
